mc_controller_hs: RTL and testbench

//  Multicycle control unit for the 16-bit accumulator-style MIPS datapath. It succeeds the fixed-timing controller.
//  - Memory: a req/ack handshake supports variable-latency memory. A bounded wait triggers a timeout fault.
//  - Illegal opcodes and illegal func codes enter a sticky TRAP state.
//  - Opcode, func and ALU-op widths are parameters.
//  - Drives all datapath muxes and strobes. Also drives the memory request interface.

---
 rtl/mc_ctrl_pkg.sv | 34 +++
 rtl/mc_alu_decoder.sv | 38 +++
 rtl/mc_controller_hs.sv | 161 ++++++++++++++++
 tb/tb_mc_controller_hs.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the handshaked multicycle controller: opcodes, ALU codes, FSM states.
package mc_ctrl_pkg;

    localparam logic [3:0] OPC_LOAD  = 4'h0;
    localparam logic [3:0] OPC_STORE = 4'h1;
    localparam logic [3:0] OPC_JUMP  = 4'h2;
    localparam logic [3:0] OPC_BRZ   = 4'h4;
    localparam logic [3:0] OPC_RTYPE = 4'h8;
    localparam logic [3:0] OPC_ADDI  = 4'hC;
    localparam logic [3:0] OPC_SUBI  = 4'hD;
    localparam logic [3:0] OPC_ANDI  = 4'hE;
    localparam logic [3:0] OPC_ORI   = 4'hF;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    typedef enum logic [3:0] {
        ST_IF, ST_ID, ST_LD_MEM, ST_LD_WB, ST_ST, ST_JMP,
        ST_BRZ, ST_R_EX, ST_R_WB, ST_I_EX, ST_I_WB, ST_TRAP
    } state_e;

    // Immediate ops C..F differ only in their two low opcode bits.
    function automatic logic [2:0] imm_alu_op(input logic [1:0] sel);
        case (sel)
            2'b00:   return ALU_ADD;
            2'b01:   return ALU_SUB;
            2'b10:   return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// One-hot R-type func decode: ALU operation, write-back controls and an illegal flag.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 9,
    parameter int ALUOP_W = 3
) (
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] alu_operation,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               illegal
);

    logic [2:0] op3;

    // Exact-match compare rejects zero, multiple and high bits in one step.
    always_comb begin
        op3       = ALU_ADD;
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        illegal   = 1'b0;
        case (func)
            FUNC_W'(9'h001): begin op3 = 3'b101; reg_write = 1'b1; reg_dst = 1'b1; end
            FUNC_W'(9'h002): begin op3 = 3'b100; reg_write = 1'b1; end
            FUNC_W'(9'h004): begin op3 = 3'b010; reg_write = 1'b1; end
            FUNC_W'(9'h008): begin op3 = 3'b011; reg_write = 1'b1; end
            FUNC_W'(9'h010): begin op3 = 3'b000; reg_write = 1'b1; end
            FUNC_W'(9'h020): begin op3 = 3'b001; reg_write = 1'b1; end
            FUNC_W'(9'h040): begin op3 = 3'b110; reg_write = 1'b1; end
            FUNC_W'(9'h080): begin op3 = 3'b111; end
            default:         illegal = 1'b1;
        endcase
    end

    assign alu_operation = ALUOP_W'(op3);

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle control FSM with req/ack memory handshake, bounded wait and sticky trap.
module mc_controller_hs
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int FUNC_W      = 9,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opc,
    input  logic [FUNC_W-1:0]  func,
    input  logic               zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_load,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_operation,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               fault
);

    localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [ALUOP_W-1:0] r_op;
    logic               r_we, r_dst, func_illegal;
    logic [3:0]         opc_lo;
    logic               opc_hi_zero, mem_state, timeout;

    mc_alu_decoder #(.FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)) u_alu_dec (
        .func          (func),
        .alu_operation (r_op),
        .reg_write     (r_we),
        .reg_dst       (r_dst),
        .illegal       (func_illegal)
    );

    assign opc_lo      = opc[3:0];
    assign opc_hi_zero = ((opc >> 4) == '0);
    assign mem_state   = (state_q == ST_IF) || (state_q == ST_LD_MEM) || (state_q == ST_ST);
    // An ack arriving in the final allowed cycle still completes the access.
    assign timeout     = mem_state && !mem_ack && (wait_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IF:     state_d = mem_ack ? ST_ID : (timeout ? ST_TRAP : ST_IF);
            ST_ID: begin
                state_d = ST_TRAP;
                if (opc_hi_zero) begin
                    case (opc_lo)
                        OPC_LOAD:  state_d = ST_LD_MEM;
                        OPC_STORE: state_d = ST_ST;
                        OPC_JUMP:  state_d = ST_JMP;
                        OPC_BRZ:   state_d = ST_BRZ;
                        OPC_RTYPE: state_d = ST_R_EX;
                        OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI: state_d = ST_I_EX;
                        default:   state_d = ST_TRAP;
                    endcase
                end
            end
            ST_LD_MEM: state_d = mem_ack ? ST_LD_WB : (timeout ? ST_TRAP : ST_LD_MEM);
            ST_ST:     state_d = mem_ack ? ST_IF : (timeout ? ST_TRAP : ST_ST);
            ST_R_EX:   state_d = func_illegal ? ST_TRAP : ST_R_WB;
            ST_I_EX:   state_d = ST_I_WB;
            ST_TRAP:   state_d = ST_TRAP;
            ST_LD_WB, ST_JMP, ST_BRZ, ST_R_WB, ST_I_WB: state_d = ST_IF;
            default:   state_d = ST_IF;
        endcase

        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (mem_state && !mem_ack && wait_q != CNT_MAX)
            wait_d = wait_q + 1'b1;
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_load       = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b01;
        alu_operation = ALUOP_W'(ALU_ADD);
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        fault         = 1'b0;
        unique case (state_q)
            ST_IF: begin
                mem_req  = 1'b1;
                ir_write = mem_ack;
                pc_load  = mem_ack;
            end
            ST_LD_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_ST: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_JMP: begin
                pc_src  = 2'b10;
                pc_load = 1'b1;
            end
            ST_BRZ: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                alu_operation = ALUOP_W'(ALU_SUB);
                pc_src        = 2'b01;
                pc_load       = zero;
            end
            ST_R_EX, ST_R_WB: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                alu_operation = r_op;
                reg_write     = (state_q == ST_R_WB) && r_we;
                reg_dst       = (state_q == ST_R_WB) && r_dst;
            end
            ST_I_EX, ST_I_WB: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_operation = ALUOP_W'(imm_alu_op(opc_lo[1:0]));
                reg_write     = (state_q == ST_I_WB);
            end
            ST_TRAP:  fault = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: per-cycle output vectors compared against hand-derived values.
module tb_mc_controller_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opc = 4'h0;
    logic [8:0] func = 9'h000;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_load;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_dst, reg_write, mem_to_reg, fault;
    logic [2:0] alu_operation;
    logic [16:0] outs;

    int checks = 0;
    int failures = 0;

    // {req,we,iord,ir_write,pc_load,pc_src,src_a,src_b,op,reg_dst,reg_write,mem_to_reg,fault}
    localparam logic [16:0] S_IF0  = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] S_IF1  = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
    localparam logic [16:0] S_ID   = 17'b0_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] S_LDM  = 17'b1_0_1_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] S_LDWB = 17'b0_0_0_0_0_00_0_01_010_0_1_1_0;
    localparam logic [16:0] S_ST   = 17'b1_1_1_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] S_JMP  = 17'b0_0_0_0_1_10_0_01_010_0_0_0_0;
    localparam logic [16:0] S_BRZ1 = 17'b0_0_0_0_1_01_1_00_011_0_0_0_0;
    localparam logic [16:0] S_BRZ0 = 17'b0_0_0_0_0_01_1_00_011_0_0_0_0;
    localparam logic [16:0] S_TRAP = 17'b0_0_0_0_0_00_0_01_010_0_0_0_1;

    mc_controller_hs dut (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_load(pc_load), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_operation(alu_operation), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .fault(fault)
    );

    assign outs = {mem_req, mem_we, iord, ir_write, pc_load, pc_src, alu_src_a,
                   alu_src_b, alu_operation, reg_dst, reg_write, mem_to_reg, fault};

    always #5 clk = ~clk;

    // Each task starts at a falling edge with the DUT in the state of its first entry.
    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== S_IF0) begin
            failures++; $display("FAIL reset_if_noack: got %b expected %b", outs, S_IF0);
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (outs !== S_IF1) begin
            failures++; $display("FAIL reset_if_ack: got %b expected %b", outs, S_IF1);
        end
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs %b", outs);
    endtask

    task automatic test_itype();
        logic [2:0] ops [4] = '{3'b010, 3'b011, 3'b000, 3'b001};
        for (int k = 0; k < 4; k++) begin
            logic [16:0] exp [4];
            opc = 4'hC + 4'(k);
            exp[0] = S_IF1;
            exp[1] = S_ID;
            exp[2] = {10'b00000_00_1_10, ops[k], 4'b0000};
            exp[3] = {10'b00000_00_1_10, ops[k], 4'b0100};
            for (int i = 0; i < 4; i++) begin
                mem_ack = 1'b1;
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL itype_opc%h[%0d]: got %b expected %b", opc, i, outs, exp[i]);
                end
                @(negedge clk);
            end
            $display("itype opc=%h: 4 cycles checked", opc);
        end
    endtask

    task automatic test_load();
        logic        acks [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
        logic [16:0] exp  [10] = '{S_IF0, S_IF0, S_IF0, S_IF1, S_ID,
                                   S_LDM, S_LDM, S_LDM, S_LDM, S_LDWB};
        opc = 4'h0;
        for (int i = 0; i < 10; i++) begin
            mem_ack = acks[i];
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++; $display("FAIL load_wait[%0d]: got %b expected %b", i, outs, exp[i]);
            end
            @(negedge clk);
        end
        $display("load with 3 wait cycles per access: 10 cycles checked");
    endtask

    task automatic test_store_jump();
        logic [16:0] exp [3];
        for (int k = 0; k < 2; k++) begin
            opc    = (k == 0) ? 4'h1 : 4'h2;
            exp[0] = S_IF1;
            exp[1] = S_ID;
            exp[2] = (k == 0) ? S_ST : S_JMP;
            for (int i = 0; i < 3; i++) begin
                mem_ack = 1'b1;
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL store_jump_opc%h[%0d]: got %b expected %b", opc, i, outs, exp[i]);
                end
                @(negedge clk);
            end
            $display("opc=%h zero-wait: 3 cycles checked", opc);
        end
    endtask

    task automatic test_brz();
        logic [16:0] exp [3];
        opc = 4'h4;
        for (int k = 0; k < 2; k++) begin
            zero   = (k == 0);
            exp[0] = S_IF1;
            exp[1] = S_ID;
            exp[2] = zero ? S_BRZ1 : S_BRZ0;
            for (int i = 0; i < 3; i++) begin
                mem_ack = 1'b1;
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL brz_zero%0d[%0d]: got %b expected %b", zero, i, outs, exp[i]);
                end
                @(negedge clk);
            end
            $display("brz zero=%0d: 3 cycles checked", zero);
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [8:0]  funcs [2] = '{9'h001, 9'h080};
        logic [2:0]  ops   [2] = '{3'b101, 3'b111};
        logic [1:0]  wb    [2] = '{2'b11, 2'b00};
        logic [16:0] exp [4];
        opc = 4'h8;
        for (int k = 0; k < 2; k++) begin
            func   = funcs[k];
            exp[0] = S_IF1;
            exp[1] = S_ID;
            exp[2] = {10'b00000_00_1_00, ops[k], 4'b0000};
            exp[3] = {10'b00000_00_1_00, ops[k], wb[k], 2'b00};
            for (int i = 0; i < 4; i++) begin
                mem_ack = 1'b1;
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL rtype_func%h[%0d]: got %b expected %b", func, i, outs, exp[i]);
                end
                @(negedge clk);
            end
            $display("rtype func=%h: 4 cycles checked", func);
        end
    endtask

    task automatic test_bad_func();
        opc = 4'h8; func = 9'h003; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== S_TRAP) begin
                failures++; $display("FAIL bad_func_trap[%0d]: got %b expected %b", i, outs, S_TRAP);
            end
            @(negedge clk);
        end
        #1;
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== S_IF0) begin
            failures++; $display("FAIL trap_async_reset: got %b expected %b", outs, S_IF0);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("func=003 trapped, async reset returned to IF");
    endtask

    task automatic test_bad_opcode();
        logic [16:0] exp [4] = '{S_IF1, S_ID, S_TRAP, S_TRAP};
        opc = 4'h3;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++; $display("FAIL bad_opcode[%0d]: got %b expected %b", i, outs, exp[i]);
            end
            @(negedge clk);
        end
        rst = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("opc=3 trapped");
    endtask

    task automatic test_timeout();
        opc = 4'h2;
        for (int i = 0; i < 18; i++) begin
            logic [16:0] exp;
            exp     = (i < 16) ? S_IF0 : S_TRAP;
            mem_ack = 1'b0;
            #1;
            checks++;
            if (outs !== exp) begin
                failures++; $display("FAIL timeout[%0d]: got %b expected %b", i, outs, exp);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("16 cycles without ack in IF: trapped");
    endtask

    task automatic test_timeout_edge();
        opc = 4'h2;
        for (int i = 0; i < 19; i++) begin
            logic [16:0] exp;
            mem_ack = (i == 15);
            exp = (i < 15) ? S_IF0 : (i == 15) ? S_IF1 : (i == 16) ? S_ID :
                  (i == 17) ? S_JMP : S_IF0;
            #1;
            checks++;
            if (outs !== exp) begin
                failures++; $display("FAIL timeout_edge[%0d]: got %b expected %b", i, outs, exp);
            end
            @(negedge clk);
        end
        $display("ack on timeout cycle: advanced without fault");
    endtask

    task automatic test_reset_mid_load();
        logic        acks [4] = '{1, 1, 0, 0};
        logic [16:0] exp  [4] = '{S_IF1, S_ID, S_LDM, S_LDM};
        opc = 4'h0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = acks[i];
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++; $display("FAIL mid_load[%0d]: got %b expected %b", i, outs, exp[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== S_IF0) begin
            failures++; $display("FAIL mid_load_reset: got %b expected %b", outs, S_IF0);
        end
        @(negedge clk);
        rst = 1'b0;
        opc = 4'h1;
        for (int i = 0; i < 3; i++) begin
            logic [16:0] e;
            e = (i == 0) ? S_IF1 : (i == 1) ? S_ID : S_ST;
            mem_ack = 1'b1;
            #1;
            checks++;
            if (outs !== e) begin
                failures++; $display("FAIL after_reset_store[%0d]: got %b expected %b", i, outs, e);
            end
            @(negedge clk);
        end
        $display("reset during LD_MEM: returned to IF, store then ran normally");
    endtask

    initial begin
        test_reset();
        test_itype();
        test_load();
        test_store_jump();
        test_brz();
        test_rtype();
        test_bad_func();
        test_bad_opcode();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
